// File: rtl/pipe_ctrl_hazard_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_hazard_if
// Decode-stage bus between the instruction front-end (IF/ID register plus
// decoder) and the control/hazard pipeline.
//   master : front-end side; drives the decoded D-stage fields and receives
//            the stall/flush requests.
//   slave  : control pipeline side; samples the D-stage fields and produces
//            the stall/flush requests.
// Signals
//   valid_d, cond_d, reg_write_d, mem_write_d, mem_to_reg_d, branch_d,
//   pc_src_d, no_write_d, alu_src_d, alu_ctrl_d, flag_write_d, extra_d,
//   ra1_d, ra2_d, wa_d           decoded instruction in D
//   stall_f, stall_d             hold PC / hold IF-ID register
//   flush_d, flush_e             bubble IF-ID / bubble into E
// -----------------------------------------------------------------------------
interface pipe_ctrl_hazard_if #(
    parameter int REG_AW   = 4,
    parameter int ALUCTL_W = 3,
    parameter int EXTRA_W  = 1
);
    logic                valid_d;
    logic [3:0]          cond_d;
    logic                reg_write_d;
    logic                mem_write_d;
    logic                mem_to_reg_d;
    logic                branch_d;
    logic                pc_src_d;
    logic                no_write_d;
    logic                alu_src_d;
    logic [ALUCTL_W-1:0] alu_ctrl_d;
    logic [1:0]          flag_write_d;
    logic [EXTRA_W-1:0]  extra_d;
    logic [REG_AW-1:0]   ra1_d;
    logic [REG_AW-1:0]   ra2_d;
    logic [REG_AW-1:0]   wa_d;
    logic                stall_f;
    logic                stall_d;
    logic                flush_d;
    logic                flush_e;

    modport master (
        output valid_d, cond_d, reg_write_d, mem_write_d, mem_to_reg_d,
               branch_d, pc_src_d, no_write_d, alu_src_d, alu_ctrl_d,
               flag_write_d, extra_d, ra1_d, ra2_d, wa_d,
        input  stall_f, stall_d, flush_d, flush_e
    );

    modport slave (
        input  valid_d, cond_d, reg_write_d, mem_write_d, mem_to_reg_d,
               branch_d, pc_src_d, no_write_d, alu_src_d, alu_ctrl_d,
               flag_write_d, extra_d, ra1_d, ra2_d, wa_d,
        output stall_f, stall_d, flush_d, flush_e
    );
endinterface

// File: rtl/pipe_ctrl_hazard.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_hazard
// D->E->M->W control pipeline of the 5-stage ARM-subset core. Carries the
// decoded control bits and register addresses down the pipe, evaluates the
// condition field in E against the flags register held here, and produces
// the forwarding selects and the stall/flush requests for the front-end.
// Ports
//   sys_clk, sys_rst_n   clock (rising edge) / asynchronous active-low reset
//   dif (slave)          decoded D-stage instruction in, stall/flush out
//   alu_flags_e          {N,Z,C,V} produced by the ALU for the E instruction
//   alu_src_e, alu_ctrl_e                E-stage ALU controls (registered)
//   branch_taken_e                       taken branch in E
//   fwd_a_e, fwd_b_e                     00 regfile, 10 M result, 01 W result
//   mem_write_m, mem_to_reg_m, reg_write_m   M-stage controls
//   reg_write_w, mem_to_reg_w, pc_src_w, wa_w, extra_w   W-stage controls
//   flags_q                              architectural {N,Z,C,V}
// -----------------------------------------------------------------------------
module pipe_ctrl_hazard #(
    parameter int REG_AW   = 4,
    parameter int ALUCTL_W = 3,
    parameter int EXTRA_W  = 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    pipe_ctrl_hazard_if.slave   dif,
    input  logic [3:0]          alu_flags_e,
    output logic                alu_src_e,
    output logic [ALUCTL_W-1:0] alu_ctrl_e,
    output logic                branch_taken_e,
    output logic [1:0]          fwd_a_e,
    output logic [1:0]          fwd_b_e,
    output logic                mem_write_m,
    output logic                mem_to_reg_m,
    output logic                reg_write_m,
    output logic                reg_write_w,
    output logic                mem_to_reg_w,
    output logic                pc_src_w,
    output logic [REG_AW-1:0]   wa_w,
    output logic [EXTRA_W-1:0]  extra_w,
    output logic [3:0]          flags_q
);

    // Forwarding select encodings
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b01;

    // ARM condition field evaluation against {N,Z,C,V}
    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
        logic n_v;
        logic z_v;
        logic c_v;
        logic v_v;
        logic res_v;
        n_v = flags[3];
        z_v = flags[2];
        c_v = flags[1];
        v_v = flags[0];
        case (cond)
            4'b0000: res_v = z_v;
            4'b0001: res_v = ~z_v;
            4'b0010: res_v = c_v;
            4'b0011: res_v = ~c_v;
            4'b0100: res_v = n_v;
            4'b0101: res_v = ~n_v;
            4'b0110: res_v = v_v;
            4'b0111: res_v = ~v_v;
            4'b1000: res_v = c_v & ~z_v;
            4'b1001: res_v = ~c_v | z_v;
            4'b1010: res_v = (n_v == v_v);
            4'b1011: res_v = (n_v != v_v);
            4'b1100: res_v = ~z_v & (n_v == v_v);
            4'b1101: res_v = z_v | (n_v != v_v);
            default: res_v = 1'b1;
        endcase
        return res_v;
    endfunction

    // E-stage registers
    logic                valid_e_r;
    logic [3:0]          cond_e_r;
    logic                reg_write_e_r;
    logic                mem_write_e_r;
    logic                mem_to_reg_e_r;
    logic                branch_e_r;
    logic                pc_src_e_r;
    logic                no_write_e_r;
    logic                alu_src_e_r;
    logic [ALUCTL_W-1:0] alu_ctrl_e_r;
    logic [1:0]          flag_write_e_r;
    logic [EXTRA_W-1:0]  extra_e_r;
    logic [REG_AW-1:0]   ra1_e_r;
    logic [REG_AW-1:0]   ra2_e_r;
    logic [REG_AW-1:0]   wa_e_r;

    // M-stage registers (enables already gated by the E condition)
    logic                reg_write_m_r;
    logic                mem_write_m_r;
    logic                mem_to_reg_m_r;
    logic                pc_src_m_r;
    logic [REG_AW-1:0]   wa_m_r;
    logic [EXTRA_W-1:0]  extra_m_r;

    // W-stage registers
    logic                reg_write_w_r;
    logic                mem_to_reg_w_r;
    logic                pc_src_w_r;
    logic [REG_AW-1:0]   wa_w_r;
    logic [EXTRA_W-1:0]  extra_w_r;

    logic [3:0]          flags_r;

    // Combinational hazard / gating terms
    logic                cond_ok_s;
    logic                en_s;
    logic                branch_taken_s;
    logic                ld_stall_s;
    logic                pc_pend_s;
    logic                flush_e_s;
    logic [1:0]          fwd_a_s;
    logic [1:0]          fwd_b_s;
    logic [3:0]          flags_next_s;

    assign cond_ok_s      = cond_check(cond_e_r, flags_r);
    assign en_s           = valid_e_r & cond_ok_s;
    assign branch_taken_s = branch_e_r & cond_ok_s & valid_e_r;

    // A load in E whose destination feeds the instruction in D cannot be
    // forwarded in time: hold D for one cycle and push a bubble into E.
    assign ld_stall_s = valid_e_r & mem_to_reg_e_r & dif.valid_d &
                        ((wa_e_r == dif.ra1_d) | (wa_e_r == dif.ra2_d));

    // A PC write anywhere from D to M means the fetch stream is wrong until it
    // retires in W; the E/D terms are ungated because the condition is not
    // known yet for D and keeping E ungated avoids a comparator on the flags path.
    assign pc_pend_s = (dif.valid_d & dif.pc_src_d) | (valid_e_r & pc_src_e_r) | pc_src_m_r;

    assign flush_e_s   = ld_stall_s | branch_taken_s;
    assign dif.stall_f = ld_stall_s | pc_pend_s;
    assign dif.stall_d = ld_stall_s;
    assign dif.flush_d = pc_pend_s | pc_src_w_r | branch_taken_s;
    assign dif.flush_e = flush_e_s;

    // Forwarding selects; the younger producer in M takes priority over W
    always_comb begin
        fwd_a_s = FWD_RF;
        fwd_b_s = FWD_RF;
        if (reg_write_m_r && (wa_m_r == ra1_e_r)) begin
            fwd_a_s = FWD_M;
        end else if (reg_write_w_r && (wa_w_r == ra1_e_r)) begin
            fwd_a_s = FWD_W;
        end else begin
            fwd_a_s = FWD_RF;
        end
        if (reg_write_m_r && (wa_m_r == ra2_e_r)) begin
            fwd_b_s = FWD_M;
        end else if (reg_write_w_r && (wa_w_r == ra2_e_r)) begin
            fwd_b_s = FWD_W;
        end else begin
            fwd_b_s = FWD_RF;
        end
    end

    // Next flags: each half is replaced only when its write enable is set
    always_comb begin
        flags_next_s = flags_r;
        if (flag_write_e_r[1]) begin
            flags_next_s[3:2] = alu_flags_e[3:2];
        end else begin
            flags_next_s[3:2] = flags_r[3:2];
        end
        if (flag_write_e_r[0]) begin
            flags_next_s[1:0] = alu_flags_e[1:0];
        end else begin
            flags_next_s[1:0] = flags_r[1:0];
        end
    end

    // D->E register; a flush loads an all-zero bubble and beats the stall
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            valid_e_r      <= 1'b0;
            cond_e_r       <= 4'b0000;
            reg_write_e_r  <= 1'b0;
            mem_write_e_r  <= 1'b0;
            mem_to_reg_e_r <= 1'b0;
            branch_e_r     <= 1'b0;
            pc_src_e_r     <= 1'b0;
            no_write_e_r   <= 1'b0;
            alu_src_e_r    <= 1'b0;
            alu_ctrl_e_r   <= {ALUCTL_W{1'b0}};
            flag_write_e_r <= 2'b00;
            extra_e_r      <= {EXTRA_W{1'b0}};
            ra1_e_r        <= {REG_AW{1'b0}};
            ra2_e_r        <= {REG_AW{1'b0}};
            wa_e_r         <= {REG_AW{1'b0}};
        end else if (flush_e_s) begin
            valid_e_r      <= 1'b0;
            cond_e_r       <= 4'b0000;
            reg_write_e_r  <= 1'b0;
            mem_write_e_r  <= 1'b0;
            mem_to_reg_e_r <= 1'b0;
            branch_e_r     <= 1'b0;
            pc_src_e_r     <= 1'b0;
            no_write_e_r   <= 1'b0;
            alu_src_e_r    <= 1'b0;
            alu_ctrl_e_r   <= {ALUCTL_W{1'b0}};
            flag_write_e_r <= 2'b00;
            extra_e_r      <= {EXTRA_W{1'b0}};
            ra1_e_r        <= {REG_AW{1'b0}};
            ra2_e_r        <= {REG_AW{1'b0}};
            wa_e_r         <= {REG_AW{1'b0}};
        end else begin
            valid_e_r      <= dif.valid_d;
            cond_e_r       <= dif.cond_d;
            reg_write_e_r  <= dif.reg_write_d;
            mem_write_e_r  <= dif.mem_write_d;
            mem_to_reg_e_r <= dif.mem_to_reg_d;
            branch_e_r     <= dif.branch_d;
            pc_src_e_r     <= dif.pc_src_d;
            no_write_e_r   <= dif.no_write_d;
            alu_src_e_r    <= dif.alu_src_d;
            alu_ctrl_e_r   <= dif.alu_ctrl_d;
            flag_write_e_r <= dif.flag_write_d;
            extra_e_r      <= dif.extra_d;
            ra1_e_r        <= dif.ra1_d;
            ra2_e_r        <= dif.ra2_d;
            wa_e_r         <= dif.wa_d;
        end
    end

    // E->M register; side-effecting enables are qualified by the condition here
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            reg_write_m_r  <= 1'b0;
            mem_write_m_r  <= 1'b0;
            mem_to_reg_m_r <= 1'b0;
            pc_src_m_r     <= 1'b0;
            wa_m_r         <= {REG_AW{1'b0}};
            extra_m_r      <= {EXTRA_W{1'b0}};
        end else begin
            reg_write_m_r  <= en_s & reg_write_e_r & ~no_write_e_r;
            mem_write_m_r  <= en_s & mem_write_e_r;
            mem_to_reg_m_r <= mem_to_reg_e_r;
            pc_src_m_r     <= en_s & pc_src_e_r;
            wa_m_r         <= wa_e_r;
            extra_m_r      <= extra_e_r;
        end
    end

    // M->W register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            reg_write_w_r  <= 1'b0;
            mem_to_reg_w_r <= 1'b0;
            pc_src_w_r     <= 1'b0;
            wa_w_r         <= {REG_AW{1'b0}};
            extra_w_r      <= {EXTRA_W{1'b0}};
        end else begin
            reg_write_w_r  <= reg_write_m_r;
            mem_to_reg_w_r <= mem_to_reg_m_r;
            pc_src_w_r     <= pc_src_m_r;
            wa_w_r         <= wa_m_r;
            extra_w_r      <= extra_m_r;
        end
    end

    // Architectural flags; bubbles and condition-failed slots leave them alone
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            flags_r <= 4'b0000;
        end else if (en_s) begin
            flags_r <= flags_next_s;
        end else begin
            flags_r <= flags_r;
        end
    end

    assign alu_src_e      = alu_src_e_r;
    assign alu_ctrl_e     = alu_ctrl_e_r;
    assign branch_taken_e = branch_taken_s;
    assign fwd_a_e        = fwd_a_s;
    assign fwd_b_e        = fwd_b_s;
    assign mem_write_m    = mem_write_m_r;
    assign mem_to_reg_m   = mem_to_reg_m_r;
    assign reg_write_m    = reg_write_m_r;
    assign reg_write_w    = reg_write_w_r;
    assign mem_to_reg_w   = mem_to_reg_w_r;
    assign pc_src_w       = pc_src_w_r;
    assign wa_w           = wa_w_r;
    assign extra_w        = extra_w_r;
    assign flags_q        = flags_r;

endmodule
